// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the data-RAM port arbiter.
package mem_pkg;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [2:0] MW_LB  = 3'b000;
  localparam logic [2:0] MW_LH  = 3'b001;
  localparam logic [2:0] MW_LW  = 3'b010;
  localparam logic [2:0] MW_LD  = 3'b011;
  localparam logic [2:0] MW_LBU = 3'b100;
  localparam logic [2:0] MW_LHU = 3'b101;
  localparam logic [2:0] MW_LWU = 3'b110;
  localparam logic [2:0] MW_SB  = 3'b000;
  localparam logic [2:0] MW_SH  = 3'b001;
  localparam logic [2:0] MW_SW  = 3'b010;
  localparam logic [2:0] MW_SD  = 3'b011;

  typedef enum logic {IDLE, WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the port arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 12
);
  logic                  if_req_valid_i;
  logic                  if_req_ready_o;
  logic [RAM_SIZE-1:0]   if_addr_i;
  logic                  if_rsp_valid_o;
  logic [DATA_WIDTH-1:0] if_rsp_data_o;
  logic                  if_rsp_err_o;

  logic                  ls_req_valid_i;
  logic                  ls_req_ready_o;
  logic [RAM_SIZE-1:0]   ls_addr_i;
  logic                  ls_we_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic [2:0]            ls_memwid_i;
  logic                  ls_rsp_valid_o;
  logic [DATA_WIDTH-1:0] ls_rsp_data_o;
  logic                  ls_rsp_err_o;

  logic [RAM_SIZE-1:0]   ram_addr_o;
  logic [1:0]            ram_access_mode_o;
  logic [DATA_WIDTH-1:0] ram_data_o;
  logic [2:0]            ram_memwid_o;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic                  ram_illegal_i;

  modport slave (
    input  if_req_valid_i, if_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    input  ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_memwid_i,
    output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    output ram_addr_o, ram_access_mode_o, ram_data_o, ram_memwid_o,
    input  ram_data_i, ram_illegal_i
  );

  modport master (
    output if_req_valid_i, if_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    output ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_memwid_i,
    input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    input  ram_addr_o, ram_access_mode_o, ram_data_o, ram_memwid_o,
    output ram_data_i, ram_illegal_i
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// LS-priority grant; IF is forced through once its refusal count hits the limit.
module mem_arb_prio (
  input  logic if_valid_i,
  input  logic ls_valid_i,
  input  logic starve_at_limit_i,
  output logic if_gnt_o,
  output logic ls_gnt_o
);
  always_comb begin
    ls_gnt_o = ls_valid_i & ~(if_valid_i & starve_at_limit_i);
    if_gnt_o = if_valid_i & (~ls_valid_i | starve_at_limit_i);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data RAM between IF and LS; one access in flight,
// registered response two cycles after accept.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int RAM_SIZE     = 12,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_WIDTH-1:0] if_rsp_data_q, if_rsp_data_d;
  logic                  if_rsp_err_q, if_rsp_err_d;
  logic                  ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_WIDTH-1:0] ls_rsp_data_q, ls_rsp_data_d;
  logic                  ls_rsp_err_q, ls_rsp_err_d;

  logic                  if_gnt, ls_gnt;
  logic                  idle, if_acc, ls_acc;
  logic [DATA_WIDTH-1:0] rsp_data;

  mem_arb_prio u_prio (
    .if_valid_i        (bus.if_req_valid_i),
    .ls_valid_i        (bus.ls_req_valid_i),
    .starve_at_limit_i (starve_cnt_q == CNT_MAX),
    .if_gnt_o          (if_gnt),
    .ls_gnt_o          (ls_gnt)
  );

  // Gating with rst keeps both readies low for the whole reset pulse.
  always_comb begin
    idle   = (state_q == IDLE) && !rst;
    if_acc = idle && if_gnt;
    ls_acc = idle && ls_gnt;
  end

  always_comb begin
    bus.ram_addr_o        = '0;
    bus.ram_access_mode_o = NONE;
    bus.ram_data_o        = '0;
    bus.ram_memwid_o      = '0;
    if (ls_acc) begin
      bus.ram_addr_o        = bus.ls_addr_i;
      bus.ram_access_mode_o = bus.ls_we_i ? WRITE : READ;
      bus.ram_data_o        = bus.ls_we_i ? bus.ls_wdata_i : '0;
      bus.ram_memwid_o      = bus.ls_memwid_i;
    end else if (if_acc) begin
      bus.ram_addr_o        = bus.if_addr_i;
      bus.ram_access_mode_o = READ;
      bus.ram_memwid_o      = MW_LW;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;

    if (if_acc) begin
      starve_cnt_d = '0;
    end else if (ls_acc && bus.if_req_valid_i && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (if_acc || ls_acc) begin
      state_d = WAIT;
      owner_d = ls_acc ? OWN_LS : OWN_IF;
      wr_d    = ls_acc && bus.ls_we_i;
      err_d   = bus.ram_illegal_i;
    end else if (state_q == WAIT) begin
      state_d = IDLE;
    end

    // Writes and illegal accesses return zero data regardless of the RAM bus.
    rsp_data       = (wr_q || err_q) ? '0 : bus.ram_data_i;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = '0;
    if_rsp_err_d   = 1'b0;
    ls_rsp_valid_d = 1'b0;
    ls_rsp_data_d  = '0;
    ls_rsp_err_d   = 1'b0;
    if (state_q == WAIT) begin
      if (owner_q == OWN_LS) begin
        ls_rsp_valid_d = 1'b1;
        ls_rsp_data_d  = rsp_data;
        ls_rsp_err_d   = err_q;
      end else begin
        if_rsp_valid_d = 1'b1;
        if_rsp_data_d  = rsp_data;
        if_rsp_err_d   = err_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      wr_q           <= 1'b0;
      err_q          <= 1'b0;
      starve_cnt_q   <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wr_q           <= wr_d;
      err_q          <= err_d;
      starve_cnt_q   <= starve_cnt_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

  always_comb begin
    bus.if_req_ready_o = if_acc;
    bus.ls_req_ready_o = ls_acc;
    bus.if_rsp_valid_o = if_rsp_valid_q;
    bus.if_rsp_data_o  = if_rsp_data_q;
    bus.if_rsp_err_o   = if_rsp_err_q;
    bus.ls_rsp_valid_o = ls_rsp_valid_q;
    bus.ls_rsp_data_o  = ls_rsp_data_q;
    bus.ls_rsp_err_o   = ls_rsp_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model of the two ports and the RAM.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int SL = 4;

  typedef struct {
    bit            is_ls;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    memwid;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    exp_mode;
    logic [2:0]    exp_memwid;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  typedef struct {
    bit            ls;
    logic [DW-1:0] data;
    bit            err;
    int            due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .RAM_SIZE(AW)) bus ();

  // Addresses 0xF00..0xFFF are outside the RAM.
  assign bus.ram_illegal_i = (bus.ram_access_mode_o != NONE) && (bus.ram_addr_o[11:8] == 4'hF);

  mem_port_arbiter #(.DATA_WIDTH(DW), .RAM_SIZE(AW), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t          vecs [7];
  bit            starve_exp [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  rsp_t          pend [$];
  rsp_t          r;
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            if_v, ls_v, busy, if_acc_prev, ls_acc_prev, exp_if, exp_ls, ls_we, is_wr, bad;
  int            starve, k, if_rsp_cnt;
  logic [AW-1:0] if_a, ls_a, acc_addr;
  logic [DW-1:0] ls_wd, rd_next, exp_d;
  logic [2:0]    ls_mw;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] junk();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] def_val(input logic [AW-1:0] a);
    return 64'hA5A5_0000_0000_0000 | {52'h0, a};
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(8))
      0: return 12'h010;
      1: return 12'h018;
      2: return 12'h100;
      3: return 12'h108;
      4: return 12'h200;
      5: return 12'h3F8;
      6: return 12'h7F0;
      7: return 12'h020;
      default: return 12'hF08;
    endcase
  endfunction

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.if_req_valid_i = 1'b0;
    bus.if_addr_i      = '0;
    bus.ls_req_valid_i = 1'b0;
    bus.ls_addr_i      = '0;
    bus.ls_we_i        = 1'b0;
    bus.ls_wdata_i     = '0;
    bus.ls_memwid_i    = '0;
    bus.ram_data_i     = junk();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    quiet();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_no_rsp(input string tag);
    check({tag, ".if_rsp_valid"}, bus.if_rsp_valid_o, 0);
    check({tag, ".ls_rsp_valid"}, bus.ls_rsp_valid_o, 0);
    check({tag, ".if_rsp_data"}, bus.if_rsp_data_o, 0);
    check({tag, ".ls_rsp_data"}, bus.ls_rsp_data_o, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    to_drive();
    quiet();
    if (v.is_ls) begin
      bus.ls_req_valid_i = 1'b1;
      bus.ls_addr_i      = v.addr;
      bus.ls_we_i        = v.we;
      bus.ls_wdata_i     = v.wdata;
      bus.ls_memwid_i    = v.memwid;
    end else begin
      bus.if_req_valid_i = 1'b1;
      bus.if_addr_i      = v.addr;
    end
    to_neg();
    check({tag, ".ready"}, v.is_ls ? bus.ls_req_ready_o : bus.if_req_ready_o, 1);
    check({tag, ".other_ready"}, v.is_ls ? bus.if_req_ready_o : bus.ls_req_ready_o, 0);
    check({tag, ".mode"}, bus.ram_access_mode_o, v.exp_mode);
    check({tag, ".addr"}, bus.ram_addr_o, v.addr);
    check({tag, ".memwid"}, bus.ram_memwid_o, v.exp_memwid);
    if (!v.is_ls || v.we) check({tag, ".wdata"}, bus.ram_data_o, v.is_ls ? v.wdata : 0);
    to_drive();
    quiet();
    bus.ram_data_i = v.ram_rdata;
    to_neg();
    check({tag, ".wait_mode"}, bus.ram_access_mode_o, NONE);
    check({tag, ".wait_addr"}, bus.ram_addr_o, 0);
    check_no_rsp({tag, ".wait"});
    to_drive();
    bus.ram_data_i = junk();
    to_neg();
    check({tag, ".rsp_valid"}, v.is_ls ? bus.ls_rsp_valid_o : bus.if_rsp_valid_o, 1);
    check({tag, ".rsp_data"}, v.is_ls ? bus.ls_rsp_data_o : bus.if_rsp_data_o, v.exp_data);
    check({tag, ".rsp_err"}, v.is_ls ? bus.ls_rsp_err_o : bus.if_rsp_err_o, v.exp_err);
    check({tag, ".other_valid"}, v.is_ls ? bus.if_rsp_valid_o : bus.ls_rsp_valid_o, 0);
    check({tag, ".other_data"}, v.is_ls ? bus.if_rsp_data_o : bus.ls_rsp_data_o, 0);
    check({tag, ".other_err"}, v.is_ls ? bus.if_rsp_err_o : bus.ls_rsp_err_o, 0);
    to_drive();
    to_neg();
    check_no_rsp({tag, ".after"});
    check({tag, ".after_err"}, v.is_ls ? bus.ls_rsp_err_o : bus.if_rsp_err_o, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{is_ls:0, we:0, addr:12'h010, wdata:0, memwid:0, ram_rdata:64'h0000_0000_00A0_0093,
                exp_mode:READ, exp_memwid:MW_LW, exp_data:64'h0000_0000_00A0_0093, exp_err:0};
    vecs[1] = '{is_ls:1, we:1, addr:12'h100, wdata:64'h0000_0000_DEAD_BEEF, memwid:MW_SW, ram_rdata:64'h5555_5555_5555_5555,
                exp_mode:WRITE, exp_memwid:MW_SW, exp_data:0, exp_err:0};
    vecs[2] = '{is_ls:1, we:0, addr:12'h100, wdata:0, memwid:MW_LW, ram_rdata:64'h0000_0000_DEAD_BEEF,
                exp_mode:READ, exp_memwid:MW_LW, exp_data:64'h0000_0000_DEAD_BEEF, exp_err:0};
    vecs[3] = '{is_ls:1, we:0, addr:12'hF80, wdata:0, memwid:MW_LW, ram_rdata:64'h1234_5678_9ABC_DEF0,
                exp_mode:READ, exp_memwid:MW_LW, exp_data:0, exp_err:1};
    vecs[4] = '{is_ls:1, we:1, addr:12'hF10, wdata:64'hCAFE_F00D_0000_0001, memwid:MW_SD, ram_rdata:64'h7777,
                exp_mode:WRITE, exp_memwid:MW_SD, exp_data:0, exp_err:1};
    vecs[5] = '{is_ls:0, we:0, addr:12'h3FC, wdata:0, memwid:0, ram_rdata:64'hFFFF_FFFF_FFFF_FFFF,
                exp_mode:READ, exp_memwid:MW_LW, exp_data:64'hFFFF_FFFF_FFFF_FFFF, exp_err:0};
    vecs[6] = '{is_ls:1, we:0, addr:12'h7FF, wdata:64'h9999, memwid:MW_LBU, ram_rdata:64'h0000_0000_0000_00C3,
                exp_mode:READ, exp_memwid:MW_LBU, exp_data:64'h0000_0000_0000_00C3, exp_err:0};

    // Reset state, with both requesters asserting valid.
    quiet();
    bus.if_req_valid_i = 1'b1;
    bus.ls_req_valid_i = 1'b1;
    to_neg();
    check("reset.if_ready", bus.if_req_ready_o, 0);
    check("reset.ls_ready", bus.ls_req_ready_o, 0);
    check("reset.mode", bus.ram_access_mode_o, NONE);
    check_no_rsp("reset");
    apply_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back LS reads with the request held through the busy cycle.
    to_drive();
    quiet();
    bus.ls_req_valid_i = 1'b1;
    bus.ls_addr_i      = 12'h020;
    bus.ls_memwid_i    = MW_LD;
    to_neg();
    check("b2b.accept1", bus.ls_req_ready_o, 1);
    to_drive();
    bus.ls_addr_i  = 12'h028;
    bus.ram_data_i = 64'h1111_2222_3333_4444;
    to_neg();
    check("b2b.busy_ready", bus.ls_req_ready_o, 0);
    check("b2b.busy_mode", bus.ram_access_mode_o, NONE);
    to_drive();
    bus.ram_data_i = junk();
    to_neg();
    check("b2b.accept2", bus.ls_req_ready_o, 1);
    check("b2b.accept2_addr", bus.ram_addr_o, 12'h028);
    check("b2b.rsp1_valid", bus.ls_rsp_valid_o, 1);
    check("b2b.rsp1_data", bus.ls_rsp_data_o, 64'h1111_2222_3333_4444);
    to_drive();
    quiet();
    bus.ram_data_i = 64'h5555_6666_7777_8888;
    to_neg();
    check("b2b.gap_valid", bus.ls_rsp_valid_o, 0);
    to_drive();
    to_neg();
    check("b2b.rsp2_valid", bus.ls_rsp_valid_o, 1);
    check("b2b.rsp2_data", bus.ls_rsp_data_o, 64'h5555_6666_7777_8888);

    // Reset asserted while an access is outstanding.
    to_drive();
    quiet();
    bus.ls_req_valid_i = 1'b1;
    bus.ls_addr_i      = 12'h030;
    bus.ls_memwid_i    = MW_LD;
    to_neg();
    check("rstw.accept", bus.ls_req_ready_o, 1);
    to_drive();
    bus.ls_addr_i  = 12'h038;
    bus.ram_data_i = 64'h3333;
    #1;
    rst = 1'b1;
    #1;
    check("rstw.mode_now", bus.ram_access_mode_o, NONE);
    to_neg();
    check("rstw.ready_wait", bus.ls_req_ready_o, 0);
    check_no_rsp("rstw.in_reset1");
    to_drive();
    to_neg();
    check("rstw.ready_idle", bus.ls_req_ready_o, 0);
    check("rstw.mode_idle", bus.ram_access_mode_o, NONE);
    check_no_rsp("rstw.in_reset2");
    to_drive();
    rst = 1'b0;
    quiet();
    to_neg();
    check_no_rsp("rstw.after1");
    to_drive();
    to_neg();
    check_no_rsp("rstw.after2");
    run_vec('{is_ls:1, we:0, addr:12'h038, wdata:0, memwid:MW_LD, ram_rdata:64'h0BAD_F00D_0000_0038,
              exp_mode:READ, exp_memwid:MW_LD, exp_data:64'h0BAD_F00D_0000_0038, exp_err:0}, "rstw.next");

    // Starvation: both requesters held valid continuously.
    apply_reset();
    bus.if_req_valid_i = 1'b1;
    bus.if_addr_i      = 12'h040;
    bus.ls_req_valid_i = 1'b1;
    bus.ls_addr_i      = 12'h080;
    bus.ls_memwid_i    = MW_LD;
    k = 0;
    if_rsp_cnt = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      to_neg();
      if (bus.if_rsp_valid_o) if_rsp_cnt++;
      if (bus.if_req_ready_o || bus.ls_req_ready_o) begin
        check($sformatf("starve.grant%0d_is_ls", k), bus.ls_req_ready_o, starve_exp[k]);
        k++;
      end
      to_drive();
    end
    check("starve.grants_seen", k, 10);
    quiet();
    for (int c = 0; c < 3; c++) begin
      to_neg();
      if (bus.if_rsp_valid_o) if_rsp_cnt++;
      to_drive();
    end
    check("starve.if_responses", if_rsp_cnt, 2);

    // Randomized traffic against the transaction-level model.
    apply_reset();
    if_v = 0; ls_v = 0; busy = 0; if_acc_prev = 0; ls_acc_prev = 0; starve = 0;
    if_a = '0; ls_a = '0; ls_we = 0; ls_wd = '0; ls_mw = '0;
    rd_next = junk();
    for (int cyc = 0; cyc < 2004; cyc++) begin
      if (cyc > 0) to_drive();
      if (if_acc_prev || (if_v && $urandom_range(15) == 0) || cyc >= 2000) if_v = 0;
      if (!if_v && cyc < 2000 && $urandom_range(2) == 0) begin
        if_v = 1;
        if_a = pick_addr();
      end
      if (ls_acc_prev || (ls_v && $urandom_range(15) == 0) || cyc >= 2000) ls_v = 0;
      if (!ls_v && cyc < 2000 && $urandom_range(2) == 0) begin
        ls_v  = 1;
        ls_a  = pick_addr();
        ls_we = $urandom_range(1) == 1;
        ls_wd = junk();
        ls_mw = 3'($urandom_range(7));
      end
      bus.if_req_valid_i = if_v;
      bus.if_addr_i      = if_a;
      bus.ls_req_valid_i = ls_v;
      bus.ls_addr_i      = ls_a;
      bus.ls_we_i        = ls_we;
      bus.ls_wdata_i     = ls_wd;
      bus.ls_memwid_i    = ls_mw;
      bus.ram_data_i     = rd_next;
      rd_next            = junk();
      to_neg();

      exp_ls = !busy && ls_v && !(if_v && starve == SL);
      exp_if = !busy && if_v && !exp_ls;
      check("rnd.if_ready", bus.if_req_ready_o, exp_if);
      check("rnd.ls_ready", bus.ls_req_ready_o, exp_ls);

      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        check("rnd.rsp_valid", r.ls ? bus.ls_rsp_valid_o : bus.if_rsp_valid_o, 1);
        check("rnd.rsp_data", r.ls ? bus.ls_rsp_data_o : bus.if_rsp_data_o, r.data);
        check("rnd.rsp_err", r.ls ? bus.ls_rsp_err_o : bus.if_rsp_err_o, r.err);
        check("rnd.other_valid", r.ls ? bus.if_rsp_valid_o : bus.ls_rsp_valid_o, 0);
      end else begin
        check_no_rsp("rnd.idle");
      end

      if_acc_prev = 0;
      ls_acc_prev = 0;
      if (exp_ls || exp_if) begin
        acc_addr = exp_ls ? ls_a : if_a;
        is_wr    = exp_ls && ls_we;
        check("rnd.mode", bus.ram_access_mode_o, is_wr ? WRITE : READ);
        check("rnd.addr", bus.ram_addr_o, acc_addr);
        check("rnd.memwid", bus.ram_memwid_o, exp_ls ? ls_mw : MW_LW);
        if (is_wr) check("rnd.wdata", bus.ram_data_o, ls_wd);

        if (bus.ram_access_mode_o == WRITE && !bus.ram_illegal_i)
          ram_mem[bus.ram_addr_o] = bus.ram_data_o;
        if (bus.ram_access_mode_o == READ && !bus.ram_illegal_i)
          rd_next = ram_mem.exists(bus.ram_addr_o) ? ram_mem[bus.ram_addr_o] : def_val(bus.ram_addr_o);

        bad = acc_addr[11:8] == 4'hF;
        if (is_wr && !bad) ref_mem[acc_addr] = ls_wd;
        exp_d = (is_wr || bad) ? '0 : (ref_mem.exists(acc_addr) ? ref_mem[acc_addr] : def_val(acc_addr));
        pend.push_back('{ls:exp_ls, data:exp_d, err:bad, due:cyc + 2});

        if (exp_if) starve = 0;
        else if (if_v && starve < SL) starve++;
        if_acc_prev = exp_if;
        ls_acc_prev = exp_ls;
        busy = 1;
      end else begin
        busy = 0;
      end
    end
    check("rnd.drained", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data RAM between two requesters: the instruction-fetch port (IF, read-only, 32-bit words) and the load/store port (LS, read/write, width selected by memwid).
- Sits between the fetch/EXU stages and the RAM instance. It arbitrates, drives the RAM access controls, tracks the one outstanding access, and returns a registered response to the requester that issued it.

Parameters:
- DATA_WIDTH, 64, data bus width.
- RAM_SIZE, 12, RAM address width in bits.
- STARVE_LIMIT, 4, consecutive refused IF arbitration cycles after which IF is forced to win once.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_valid_i  in  1  IF request valid
- if_req_ready_o  out  1  IF request accepted this cycle
- if_addr_i  in  RAM_SIZE  IF word address
- if_rsp_valid_o  out  1  IF response valid (1-cycle pulse)
- if_rsp_data_o  out  DATA_WIDTH  IF read data
- if_rsp_err_o  out  1  IF access illegal
- ls_req_valid_i  in  1  LS request valid
- ls_req_ready_o  out  1  LS request accepted this cycle
- ls_addr_i  in  RAM_SIZE  LS address
- ls_we_i  in  1  1 = write, 0 = read
- ls_wdata_i  in  DATA_WIDTH  LS write data
- ls_memwid_i  in  3  LS access width (funct3 encoding)
- ls_rsp_valid_o  out  1  LS response valid (1-cycle pulse)
- ls_rsp_data_o  out  DATA_WIDTH  LS read data; 0 for writes
- ls_rsp_err_o  out  1  LS access illegal
- ram_addr_o  out  RAM_SIZE  RAM address
- ram_access_mode_o  out  2  0 = NONE, 1 = READ, 2 = WRITE
- ram_data_o  out  DATA_WIDTH  RAM write data
- ram_memwid_o  out  3  RAM access width
- ram_data_i  in  DATA_WIDTH  RAM read data, valid the cycle after the access
- ram_illegal_i  in  1  RAM illegal-access flag, combinational in the access cycle

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE, starve_cnt = 0, pending owner cleared.
  - All rsp_valid/rsp_data/rsp_err outputs = 0.
  - ram_access_mode_o = NONE; both ready outputs = 0.
  - Any in-flight access is dropped with no response. Requesters must reissue after reset.
- States:
  - IDLE: may accept a request.
  - WAIT: one access outstanding; no accept.
- Arbitration (IDLE only, combinational):
  - LS wins over IF by default.
  - IF wins instead when both are valid and starve_cnt == STARVE_LIMIT.
  - Exactly one ready output goes high: the winner's, and only if its valid is high. Ready never depends on the loser's valid.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle where IF is valid but LS is granted.
  - Clears to 0 on an IF grant.
  - Holds otherwise, including in WAIT.
- Accept cycle N (valid & ready):
  - ram_* outputs are driven combinationally from the winner in cycle N.
  - IF access: mode READ, memwid 3'b010, data 0.
  - LS access: mode WRITE if ls_we_i, else READ.
  - The arbiter registers the owner, the write flag, and ram_illegal_i as err. Next state = WAIT.
  - In every cycle with no accept, ram_access_mode_o = NONE and ram_addr_o/ram_data_o/ram_memwid_o = 0.
- WAIT (cycle N+1):
  - ram_data_i is registered into the owner's rsp_data (0 for writes, and 0 when err).
  - Next state = IDLE.
- Response (cycle N+2):
  - The owner's rsp_valid pulses for exactly one cycle, with data and err. The other port's rsp outputs stay 0.
  - rsp_data/rsp_err hold their value only while rsp_valid is high; they are 0 otherwise.
- Timing:
  - Latency from accept to response is 2 cycles.
  - Peak throughput is one access per 2 cycles. A new accept in cycle N+2 overlaps the response pulse of the previous access.
- Boundary cases:
  - Request valid during WAIT: ready = 0. The requester must hold valid, addr and data stable until accepted.
  - Illegal access: a response is still returned, with err = 1. An illegal write still presents mode WRITE; the RAM is responsible for suppressing it.
  - Deassertion of valid before accept is permitted and has no side effect.

Decomposition:
- Shared package (mem_pkg):
  - RAM access-mode constants NONE = 0, READ = 1, WRITE = 2.
  - memwid encodings (LB..LWU/LD, SB..SD).
  - Arbiter state enum IDLE/WAIT and owner enum OWN_IF/OWN_LS.
- Sub-module: mem_arb_prio — combinational LS-priority grant with starvation override; inputs are the two valids and starve_at_limit, outputs are the two grants.

Test Plan:
- IF read, addr 0x010, RAM returns 0x00000000_00A00093 → ram mode READ with memwid 3'b010 in cycle N; if_rsp_valid_o for 1 cycle at N+2 with that data, err 0.
- LS write, addr 0x100, data 0xDEADBEEF, memwid SW; then LS read of 0x100 → write response with data 0 and err 0; read response data 0xDEADBEEF, 2 cycles after its accept.
- IF and LS both held valid continuously, STARVE_LIMIT = 4 → grant sequence LS, LS, LS, LS, IF, LS, ...; starve_cnt returns to 0 after the IF grant; no IF request lost.
- LS read at illegal address with ram_illegal_i = 1 → ls_rsp_err_o = 1, ls_rsp_data_o = 0 at N+2; IF response outputs remain 0.
- Back-to-back LS reads → accepts at N and N+2; response 1 pulses at N+2 in the same cycle as the second accept; ls_req_ready_o = 0 at N+1.
- rst asserted in WAIT → immediate return to IDLE; no response pulse; ram mode NONE; the next request is accepted normally after rst deasserts.
